wb_write_port: RTL and testbench

Writeback-side driver for the register file's single write port (`WE3`/`A3`/`WD3`). It merges two result sources onto that port:
- the in-order pipeline writeback stage, which is single-cycle and always wins;
- a multi-cycle multiply/divide unit, which hands off results over a valid/ready handshake and is buffered in a small FIFO until the port is free.

It also reports which registers still have buffered, unwritten results, so the hazard unit can stall readers of those registers.

---
 rtl/wb_write_port.sv | 109 ++++++++++
 tb/tb_wb_write_port.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_port.sv
// Register-file write-port arbiter: the pipeline writeback stage always wins, and
// mul/div results wait in a small FIFO until the port is free.
module wb_write_port #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWriteW,
  input  logic [4:0]               WriteRegW,
  input  logic [31:0]              ResultW,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [4:0]               md_reg,
  input  logic [31:0]              md_data,
  input  logic [4:0]               q_a1,
  input  logic [4:0]               q_a2,
  output logic                     q_busy1,
  output logic                     q_busy2,
  output logic [$clog2(DEPTH):0]   md_count,
  output logic                     WE3,
  output logic [4:0]               A3,
  output logic [31:0]              WD3
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [4:0]       r_reg  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_pipe_win;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_pipe_win = RegWriteW && (WriteRegW != 5'd0);

  // Results for $0 complete the handshake but are dropped rather than buffered.
  assign md_ready   = !w_full && !reset;
  assign w_push     = md_valid && md_ready && (md_reg != 5'd0);
  assign w_pop      = !reset && !w_pipe_win && !w_empty;
  assign md_count   = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is qualified by r_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg[r_wr_ptr]  <= md_reg;
      r_data[r_wr_ptr] <= md_data;
    end
  end

  always_comb begin
    WE3 = 1'b0;
    A3  = 5'd0;
    WD3 = 32'd0;
    if (!reset) begin
      if (w_pipe_win) begin
        WE3 = 1'b1;
        A3  = WriteRegW;
        WD3 = ResultW;
      end else if (!w_empty) begin
        WE3 = 1'b1;
        A3  = r_reg[r_rd_ptr];
        WD3 = r_data[r_rd_ptr];
      end
    end
  end

  // The head entry stays busy through its pop cycle; the regfile bypass covers that cycle.
  always_comb begin
    q_busy1 = 1'b0;
    q_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (q_a1 != 5'd0) && (r_reg[i] == q_a1)) q_busy1 = 1'b1;
      if (r_vld[i] && (q_a2 != 5'd0) && (r_reg[i] == q_a2)) q_busy2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_write_port.sv
// Bench for wb_write_port: a negedge scoreboard tracks buffered mul/div results and
// checks the port every cycle, while scenario tasks check hand-derived values inline.
module tb_wb_write_port;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWriteW;
  logic [4:0]    WriteRegW;
  logic [31:0]   ResultW;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_reg;
  logic [31:0]   md_data;
  logic [4:0]    q_a1;
  logic [4:0]    q_a2;
  logic          q_busy1;
  logic          q_busy2;
  logic [CW-1:0] md_count;
  logic          WE3;
  logic [4:0]    A3;
  logic [31:0]   WD3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;
  ent_t mdq[$];

  wb_write_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .md_count(md_count), .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  // Scoreboard: expectations for the coming edge, then commit the model's push/pop.
  always @(negedge clk) begin
    logic          e_we, e_rdy, e_b1, e_b2, pipe;
    logic [4:0]    e_a;
    logic [31:0]   e_d;
    logic [CW-1:0] e_cnt;
    e_we = 1'b0; e_a = 5'd0; e_d = 32'd0; e_b1 = 1'b0; e_b2 = 1'b0; pipe = 1'b0;
    if (reset) begin
      mdq.delete();
      e_rdy = 1'b0;
      e_cnt = '0;
    end else begin
      e_rdy = (mdq.size() < DEPTH);
      e_cnt = CW'(mdq.size());
      pipe  = RegWriteW && (WriteRegW != 5'd0);
      if (pipe) begin
        e_we = 1'b1; e_a = WriteRegW; e_d = ResultW;
      end else if (mdq.size() > 0) begin
        e_we = 1'b1; e_a = mdq[0].r; e_d = mdq[0].d;
      end
      foreach (mdq[i]) begin
        if (q_a1 != 5'd0 && mdq[i].r == q_a1) e_b1 = 1'b1;
        if (q_a2 != 5'd0 && mdq[i].r == q_a2) e_b2 = 1'b1;
      end
    end
    n_cmp++; if (WE3 !== e_we) begin n_err++; $display("FAIL sb_we t=%0t: got %0h want %0h", $time, WE3, e_we); end
    n_cmp++; if (A3 !== e_a) begin n_err++; $display("FAIL sb_a3 t=%0t: got %0d want %0d", $time, A3, e_a); end
    n_cmp++; if (WD3 !== e_d) begin n_err++; $display("FAIL sb_wd3 t=%0t: got %0h want %0h", $time, WD3, e_d); end
    n_cmp++; if (md_ready !== e_rdy) begin n_err++; $display("FAIL sb_ready t=%0t: got %0h want %0h", $time, md_ready, e_rdy); end
    n_cmp++; if (md_count !== e_cnt) begin n_err++; $display("FAIL sb_count t=%0t: got %0d want %0d", $time, md_count, e_cnt); end
    n_cmp++; if (q_busy1 !== e_b1) begin n_err++; $display("FAIL sb_busy1 t=%0t: got %0h want %0h", $time, q_busy1, e_b1); end
    n_cmp++; if (q_busy2 !== e_b2) begin n_err++; $display("FAIL sb_busy2 t=%0t: got %0h want %0h", $time, q_busy2, e_b2); end
    if (!reset) begin
      if (!pipe && mdq.size() > 0) void'(mdq.pop_front());
      if (md_valid && e_rdy && md_reg != 5'd0) mdq.push_back({md_reg, md_data});
    end
  end

  task automatic idle();
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
    q_a1 = 5'd0; q_a2 = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h55;
    md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h33;
    #1;
    n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0h want 0", WE3); end
    n_cmp++; if (A3 !== 5'd0 || WD3 !== 32'd0) begin n_err++; $display("FAIL rst_addr_data: got %0d/%0h want 0/0", A3, WD3); end
    n_cmp++; if (md_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0h want 0", md_ready); end
    n_cmp++; if (md_count !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", md_count); end
    @(posedge clk);
    step();
    reset = 1'b0;
    idle();
    #1;
    n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %0h want 1", md_ready); end
    n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL rst_release_we: got %0h want 0", WE3); end
    step();
  endtask

  task automatic test_idle_drain();
    idle(); md_valid = 1'b1; md_reg = 5'd5; md_data = 32'h1234; #1;
    n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL drain_no_passthru: got %0h want 0", WE3); end
    step();
    idle(); #1;
    n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h1234)
      begin n_err++; $display("FAIL drain_write: got %0h/%0d/%0h want 1/5/1234", WE3, A3, WD3); end
    n_cmp++; if (md_count !== CW'(1)) begin n_err++; $display("FAIL drain_count: got %0d want 1", md_count); end
    step(); #1;
    n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL drain_after: got %0h want 0", WE3); end
    step();
  endtask

  task automatic test_priority();
    idle(); RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h77;
    md_valid = 1'b1; md_reg = 5'd3; md_data = 32'hA; #1;
    n_cmp++; if (A3 !== 5'd7 || WD3 !== 32'h77) begin n_err++; $display("FAIL prio_c1: got %0d/%0h want 7/77", A3, WD3); end
    step();
    md_reg = 5'd4; md_data = 32'hB; #1;
    n_cmp++; if (A3 !== 5'd7) begin n_err++; $display("FAIL prio_c2: got %0d want 7", A3); end
    step();
    md_valid = 1'b0; #1;
    n_cmp++; if (A3 !== 5'd7) begin n_err++; $display("FAIL prio_c3: got %0d want 7", A3); end
    n_cmp++; if (md_ready !== 1'b0 || md_count !== CW'(2))
      begin n_err++; $display("FAIL prio_full: got ready=%0h cnt=%0d want 0/2", md_ready, md_count); end
    step();
    RegWriteW = 1'b0; #1;
    n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'hA)
      begin n_err++; $display("FAIL prio_first: got %0h/%0d/%0h want 1/3/a", WE3, A3, WD3); end
    step(); #1;
    n_cmp++; if (A3 !== 5'd4 || WD3 !== 32'hB) begin n_err++; $display("FAIL prio_second: got %0d/%0h want 4/b", A3, WD3); end
    step(); #1;
    n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL prio_done: got %0h want 0", WE3); end
    step();
  endtask

  task automatic test_full_pop();
    idle(); RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'h1;
    md_valid = 1'b1; md_reg = 5'd10; md_data = 32'h10; #1; step();
    md_reg = 5'd11; md_data = 32'h11; #1; step();
    RegWriteW = 1'b0; md_reg = 5'd12; md_data = 32'h12; #1;
    n_cmp++; if (md_count !== CW'(2) || md_ready !== 1'b0)
      begin n_err++; $display("FAIL full_popcyc: got cnt=%0d ready=%0h want 2/0", md_count, md_ready); end
    n_cmp++; if (A3 !== 5'd10) begin n_err++; $display("FAIL full_head: got %0d want 10", A3); end
    step();
    RegWriteW = 1'b1; WriteRegW = 5'd2; ResultW = 32'h2; #1;
    n_cmp++; if (md_count !== CW'(1) || md_ready !== 1'b1)
      begin n_err++; $display("FAIL full_next: got cnt=%0d ready=%0h want 1/1", md_count, md_ready); end
    step();
    RegWriteW = 1'b0; md_valid = 1'b0; #1;
    n_cmp++; if (md_count !== CW'(2) || A3 !== 5'd11)
      begin n_err++; $display("FAIL full_refill: got cnt=%0d a3=%0d want 2/11", md_count, A3); end
    step(); #1;
    n_cmp++; if (A3 !== 5'd12 || WD3 !== 32'h12) begin n_err++; $display("FAIL full_last: got %0d/%0h want 12/12", A3, WD3); end
    step(); step();
  endtask

  task automatic test_zero_reg();
    idle(); md_valid = 1'b1; md_reg = 5'd0; md_data = 32'hDEAD; #1;
    n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %0h want 1", md_ready); end
    step();
    idle(); #1;
    n_cmp++; if (md_count !== '0 || WE3 !== 1'b0)
      begin n_err++; $display("FAIL zero_dropped: got cnt=%0d we=%0h want 0/0", md_count, WE3); end
    step();
    RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'h11;
    md_valid = 1'b1; md_reg = 5'd6; md_data = 32'h66; #1; step();
    md_valid = 1'b0; WriteRegW = 5'd0; ResultW = 32'h99; #1;
    n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd6 || WD3 !== 32'h66)
      begin n_err++; $display("FAIL zero_pipe_drain: got %0h/%0d/%0h want 1/6/66", WE3, A3, WD3); end
    step();
    RegWriteW = 1'b0; #1;
    n_cmp++; if (md_count !== '0 || WE3 !== 1'b0)
      begin n_err++; $display("FAIL zero_pipe_after: got cnt=%0d we=%0h want 0/0", md_count, WE3); end
    step();
  endtask

  task automatic test_busy();
    idle(); RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'h1;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h9; q_a1 = 5'd9; q_a2 = 5'd0; #1;
    n_cmp++; if (q_busy1 !== 1'b0) begin n_err++; $display("FAIL busy_before: got %0h want 0", q_busy1); end
    step();
    md_valid = 1'b0; #1;
    n_cmp++; if (q_busy1 !== 1'b1 || q_busy2 !== 1'b0)
      begin n_err++; $display("FAIL busy_held: got %0h/%0h want 1/0", q_busy1, q_busy2); end
    step();
    RegWriteW = 1'b0; #1;
    n_cmp++; if (q_busy1 !== 1'b1 || A3 !== 5'd9)
      begin n_err++; $display("FAIL busy_popcyc: got busy=%0h a3=%0d want 1/9", q_busy1, A3); end
    step(); #1;
    n_cmp++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0)
      begin n_err++; $display("FAIL busy_after: got %0h/%0h want 0/0", q_busy1, q_busy2); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      idle(); md_valid = 1'b1; md_reg = 5'(i + 1); md_data = 32'(100 + i); #1;
      if (i > 0) begin
        n_cmp++; if (A3 !== 5'(i) || WD3 !== 32'(99 + i) || md_count !== CW'(1))
          begin n_err++; $display("FAIL b2b_%0d: got a3=%0d wd=%0d cnt=%0d want %0d/%0d/1", i, A3, WD3, md_count, i, 99 + i); end
      end
      step();
    end
    idle(); #1;
    n_cmp++; if (A3 !== 5'd6) begin n_err++; $display("FAIL b2b_tail: got %0d want 6", A3); end
    step();
    for (int i = 0; i < 80; i++) begin
      RegWriteW = ($urandom_range(0, 2) == 0);
      WriteRegW = 5'($urandom_range(0, 31));
      ResultW   = $urandom;
      md_valid  = 1'($urandom_range(0, 1));
      md_reg    = 5'($urandom_range(0, 15));
      md_data   = $urandom;
      q_a1      = 5'($urandom_range(0, 15));
      q_a2      = 5'($urandom_range(0, 15));
      step();
    end
    idle();
    repeat (4) step();
  endtask

  task automatic test_reset_midflight();
    idle(); RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h7;
    md_valid = 1'b1; md_reg = 5'd20; md_data = 32'h20; q_a1 = 5'd20; #1; step();
    md_reg = 5'd21; md_data = 32'h21; #1; step();
    md_valid = 1'b0; #1;
    n_cmp++; if (md_count !== CW'(2)) begin n_err++; $display("FAIL mid_prefill: got %0d want 2", md_count); end
    reset = 1'b1; #1;
    n_cmp++; if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0)
      begin n_err++; $display("FAIL mid_port: got %0h/%0d/%0h want 0/0/0", WE3, A3, WD3); end
    n_cmp++; if (md_count !== '0 || md_ready !== 1'b0 || q_busy1 !== 1'b0)
      begin n_err++; $display("FAIL mid_state: got cnt=%0d ready=%0h busy=%0h want 0/0/0", md_count, md_ready, q_busy1); end
    step();
    reset = 1'b0; RegWriteW = 1'b0; #1;
    n_cmp++; if (md_ready !== 1'b1 || md_count !== '0 || WE3 !== 1'b0)
      begin n_err++; $display("FAIL mid_release: got ready=%0h cnt=%0d we=%0h want 1/0/0", md_ready, md_count, WE3); end
    step(); #1;
    n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %0h want 0", WE3); end
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_idle_drain();
    test_priority();
    test_full_pop();
    test_zero_reg();
    test_busy();
    test_back_to_back();
    test_reset_midflight();
    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
